// File: rtl/dcache_wb_param_if.sv
// Bundle of the LSU-side request/flush handshake and the word-wide memory beat port.
// The cache uses the slave modport; the LSU/memory side uses master.
interface dcache_wb_param_if;
  logic        req_valid_i;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        stall_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        flush_i;
  logic        flush_done_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, flush_i,
    input  mem_rdata_i, mem_ready_i,
    output stall_o, rvalid_o, rdata_o, flush_done_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, flush_i,
    output mem_rdata_i, mem_ready_i,
    input  stall_o, rvalid_o, rdata_o, flush_done_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_wb_param.sv
// Direct-mapped write-back/write-allocate data cache with multi-word lines,
// burst writeback/refill over a valid/ready beat port, full flush and hit/miss counters.
module dcache_wb_param #(
  parameter int NUM_SETS       = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dcache_wb_param_if.slave bus,
  output logic [CNT_W-1:0] hit_count_o,
  output logic [CNT_W-1:0] miss_count_o
);
  localparam int WO     = $clog2(WORDS_PER_LINE);
  localparam int IX     = $clog2(NUM_SETS);
  localparam int TW     = 30 - WO - IX;
  localparam int WB     = (WO > 0) ? WO : 1;
  localparam int PW     = IX + WO;
  localparam int IX_SH  = 2 + WO;
  localparam int TAG_SH = 2 + WO + IX;

  typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB} state_t;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [IX-1:0] idx;
    logic [WB-1:0] word;
  } req_dec_t;

  state_t                      state_q, state_d;
  logic [NUM_SETS-1:0]         valid_q, dirty_q;
  logic [NUM_SETS-1:0][TW-1:0] tag_q;
  logic [31:0]                 data_q [NUM_SETS*WORDS_PER_LINE];

  logic [WB-1:0]    beat_q;
  logic [IX-1:0]    scan_q, wb_idx;
  logic             flush_pend_q, rvalid_q, flush_done_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] hit_q, miss_q;

  req_dec_t rq;
  logic     hit, flush_req, beat_done, last_beat;
  logic     hit_inc, miss_inc, rd_hit, wr_hit, refill_wr, line_fill;
  logic     wb_line_done, scan_adv, flush_end, flush_take;

  // Word-granular pointer into the flat data array; the word field vanishes when lines are one word.
  function automatic logic [PW-1:0] ptr(input logic [IX-1:0] i, input logic [WB-1:0] b);
    ptr = (PW'(i) << WO) | PW'(32'(b) & 32'(WORDS_PER_LINE - 1));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [TW-1:0] t, input logic [IX-1:0] i,
                                            input logic [WB-1:0] b);
    beat_addr = (32'(t) << TAG_SH) | (32'(i) << IX_SH) |
                ((32'(b) & 32'(WORDS_PER_LINE - 1)) << 2);
  endfunction

  always_comb begin
    rq      = '0;
    rq.tag  = TW'(bus.req_addr_i >> TAG_SH);
    rq.idx  = IX'(bus.req_addr_i >> IX_SH);
    rq.word = WB'((bus.req_addr_i >> 2) & 32'(WORDS_PER_LINE - 1));
  end

  assign hit       = valid_q[rq.idx] && (tag_q[rq.idx] == rq.tag);
  assign flush_req = flush_pend_q | bus.flush_i;
  assign beat_done = bus.mem_req_o & bus.mem_ready_i;
  assign last_beat = (beat_q == WB'(WORDS_PER_LINE - 1));
  assign wb_idx    = (state_q == FLUSH_WB) ? scan_q : rq.idx;

  always_comb begin
    state_d         = state_q;
    bus.stall_o     = 1'b1;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    rd_hit          = 1'b0;
    wr_hit          = 1'b0;
    refill_wr       = 1'b0;
    line_fill       = 1'b0;
    wb_line_done    = 1'b0;
    scan_adv        = 1'b0;
    flush_end       = 1'b0;
    flush_take      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.stall_o = 1'b0;
        // A flush raised in the same cycle as a request wins over it.
        if (flush_req) begin
          bus.stall_o = 1'b1;
          flush_take  = 1'b1;
          state_d     = FLUSH_SCAN;
        end else if (bus.req_valid_i) begin
          if (hit) begin
            hit_inc = 1'b1;
            rd_hit  = ~bus.req_we_i;
            wr_hit  = bus.req_we_i;
          end else begin
            bus.stall_o = 1'b1;
            miss_inc    = 1'b1;
            state_d     = (valid_q[rq.idx] && dirty_q[rq.idx]) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK, FLUSH_WB: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = beat_addr(tag_q[wb_idx], wb_idx, beat_q);
        bus.mem_wdata_o = data_q[ptr(wb_idx, beat_q)];
        if (beat_done && last_beat) begin
          if (state_q == WRITEBACK) state_d = REFILL;
          else begin
            wb_line_done = 1'b1;
            state_d      = FLUSH_SCAN;
          end
        end
      end
      REFILL: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = beat_addr(rq.tag, rq.idx, beat_q);
        refill_wr      = beat_done;
        if (beat_done && last_beat) begin
          line_fill = 1'b1;
          state_d   = IDLE;
        end
      end
      FLUSH_SCAN: begin
        // A written-back line comes back here clean, so the same set is re-examined once.
        if (valid_q[scan_q] && dirty_q[scan_q]) state_d = FLUSH_WB;
        else if (scan_q == IX'(NUM_SETS - 1)) begin
          flush_end = 1'b1;
          state_d   = IDLE;
        end else scan_adv = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      beat_q       <= '0;
      scan_q       <= '0;
      flush_pend_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      flush_done_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      rvalid_q     <= rd_hit;
      flush_done_q <= flush_end;
      flush_pend_q <= flush_take ? 1'b0 : (flush_pend_q | bus.flush_i);
      if (rd_hit)    rdata_q <= data_q[ptr(rq.idx, rq.word)];
      if (beat_done) beat_q  <= last_beat ? '0 : beat_q + WB'(1);
      if (wr_hit)    dirty_q[rq.idx] <= 1'b1;
      if (line_fill) begin
        valid_q[rq.idx] <= 1'b1;
        dirty_q[rq.idx] <= 1'b0;
        tag_q[rq.idx]   <= rq.tag;
      end
      if (wb_line_done) dirty_q[scan_q] <= 1'b0;
      if (flush_take)   scan_q <= '0;
      if (scan_adv)     scan_q <= scan_q + IX'(1);
      if (flush_end) begin
        valid_q <= '0;
        dirty_q <= '0;
      end
      if (hit_inc  && (hit_q  != '1)) hit_q  <= hit_q  + CNT_W'(1);
      if (miss_inc && (miss_q != '1)) miss_q <= miss_q + CNT_W'(1);
    end
  end

  // Data words carry no reset; only valid/dirty decide what is live.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (wr_hit)         data_q[ptr(rq.idx, rq.word)] <= bus.req_wdata_i;
      else if (refill_wr) data_q[ptr(rq.idx, beat_q)]  <= bus.mem_rdata_i;
    end
  end

  assign bus.rvalid_o     = rvalid_q;
  assign bus.rdata_o      = rdata_q;
  assign bus.flush_done_o = flush_done_q;
  assign hit_count_o      = hit_q;
  assign miss_count_o     = miss_q;
endmodule

// File: tb/tb_dcache_wb_param.sv
// Random + directed bench: flat-memory reference view and scoreboard for load data,
// a beat log and stall/hold monitors around the memory port, and a small saturating config.
module tb_dcache_wb_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_wb_param_if bus();
  dcache_wb_param_if bus2();
  logic [31:0] hit_cnt, miss_cnt;
  logic [1:0]  hit2, miss2;

  dcache_wb_param #(.NUM_SETS(16), .WORDS_PER_LINE(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .hit_count_o(hit_cnt), .miss_count_o(miss_cnt));
  dcache_wb_param #(.NUM_SETS(8), .WORDS_PER_LINE(1), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .bus(bus2), .hit_count_o(hit2), .miss_count_o(miss2));

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory contents as seen by the beat port, and the flat view the processor should see.
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  function automatic logic [31:0] dmem_rd(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_val(a);
  endfunction

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;
  beat_t blog[$];

  always @(posedge clk) begin
    if (!rst && bus.mem_req_o && bus.mem_ready_i) begin
      blog.push_back('{we: bus.mem_we_o, addr: bus.mem_addr_o,
                       data: bus.mem_we_o ? bus.mem_wdata_o : bus.mem_rdata_i});
      if (bus.mem_we_o) dmem[bus.mem_addr_o] = bus.mem_wdata_o;
    end
  end

  // Memory responder with per-beat wait states; also checks beat hold and stall during bursts.
  int fixed_delay = 3;
  int wcnt = 0, cur_delay = 0;
  bit h_valid = 0;
  logic h_we;
  logic [31:0] h_addr, h_wdata;
  always @(negedge clk) begin
    if (h_valid && !rst) begin
      chk("hold_req", 32'(bus.mem_req_o), 32'd1);
      chk("hold_we", 32'(bus.mem_we_o), 32'(h_we));
      chk("hold_addr", bus.mem_addr_o, h_addr);
      chk("hold_wdata", bus.mem_wdata_o, h_wdata);
    end
    if (!rst && bus.mem_req_o) chk("stall_in_burst", 32'(bus.stall_o), 32'd1);
    if (rst || !bus.mem_req_o || bus.mem_ready_i) begin
      wcnt = 0;
      cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
    end
    if (!rst && bus.mem_req_o) begin
      bus.mem_ready_i = (wcnt >= cur_delay);
      if (!bus.mem_ready_i) wcnt++;
    end else bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = bus.mem_ready_i ? dmem_rd(bus.mem_addr_o) : $urandom;
    h_valid = !rst && bus.mem_req_o && !bus.mem_ready_i;
    h_we    = bus.mem_we_o;
    h_addr  = bus.mem_addr_o;
    h_wdata = bus.mem_wdata_o;
  end

  logic [31:0] sbq[$];
  int fdone = 0;
  always @(negedge clk) begin
    if (!rst && bus.rvalid_o) begin
      chk("rvalid_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) chk("rdata", bus.rdata_o, sbq.pop_front());
    end
    if (!rst && bus.flush_done_o) fdone++;
  end

  // Second configuration: memory always ready, data derived from the beat address.
  assign bus2.mem_ready_i = 1'b1;
  assign bus2.mem_rdata_i = bus2.mem_addr_o ^ 32'h0BAD_F00D;
  int beats2 = 0;
  logic [31:0] sb2[$];
  always @(posedge clk) if (!rst && bus2.mem_req_o) beats2++;
  always @(negedge clk) begin
    if (!rst && bus2.rvalid_o) begin
      chk("rvalid2_expected", 32'(sb2.size() != 0), 32'd1);
      if (sb2.size() != 0) chk("rdata2", bus2.rdata_o, sb2.pop_front());
    end
  end

  // Reference residency: direct-mapped, set = addr[7:4], tag = addr[31:8].
  bit          res_valid [16];
  logic [23:0] res_tag   [16];
  int exp_hits = 0, exp_misses = 0;

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input bit fl, output int stalls);
    int s;
    logic [23:0] tg;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wd;
    bus.flush_i     = fl;
    if (fl) foreach (res_valid[i]) res_valid[i] = 1'b0;
    s  = int'(addr[7:4]);
    tg = addr[31:8];
    if (res_valid[s] && res_tag[s] == tg) exp_hits++;
    else begin
      exp_misses++;
      exp_hits++;
      res_valid[s] = 1'b1;
      res_tag[s]   = tg;
    end
    if (we) refm[{addr[31:2], 2'b00}] = wd;
    else sbq.push_back(ref_rd({addr[31:2], 2'b00}));
    stalls = 0;
    forever begin
      #1;
      if (!bus.stall_o) break;
      @(negedge clk);
      bus.flush_i = 1'b0;
      stalls++;
      if (stalls > 2000) begin
        chk("access_timeout", 32'(stalls), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
  endtask

  task automatic chk_burst(input string n, input int at, input logic we, input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      chk({n, "_present"}, 32'(at + i < blog.size()), 32'd1);
      if (at + i < blog.size()) begin
        chk({n, "_we"}, 32'(blog[at+i].we), 32'(we));
        chk({n, "_addr"}, blog[at+i].addr, base + 32'(4 * i));
      end
    end
  endtask

  task automatic access2(input logic [31:0] addr, output int nb);
    int b0, n;
    b0 = beats2;
    n  = 0;
    @(negedge clk);
    bus2.req_valid_i = 1'b1;
    bus2.req_we_i    = 1'b0;
    bus2.req_addr_i  = addr;
    sb2.push_back(addr ^ 32'h0BAD_F00D);
    forever begin
      #1;
      if (!bus2.stall_o) break;
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("access2_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus2.req_valid_i = 1'b0;
    nb = beats2 - b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, b0, f0, n;
    logic [31:0] ev [4];
    logic [31:0] a;
    logic we;
    bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_addr_i = 0; bus.req_wdata_i = 0; bus.flush_i = 0;
    bus2.req_valid_i = 0; bus2.req_we_i = 0; bus2.req_addr_i = 0; bus2.req_wdata_i = 0; bus2.flush_i = 0;
    foreach (res_valid[i]) res_valid[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dmem[32'h1040 + 32'(4*i)] = 32'hA0 + 32'(i);
      refm[32'h1040 + 32'(4*i)] = 32'hA0 + 32'(i);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(bus.stall_o), 0);
    chk("rst_rvalid", 32'(bus.rvalid_o), 0);
    chk("rst_flush_done", 32'(bus.flush_done_o), 0);
    chk("rst_mem_req", 32'(bus.mem_req_o), 0);
    chk("rst_mem_we", 32'(bus.mem_we_o), 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 0);
    chk("rst_hits", hit_cnt, 0);
    chk("rst_misses", miss_cnt, 0);

    // Cold miss, 3 wait states before every beat.
    b0 = blog.size();
    access(0, 32'h1040, 0, 0, st);
    chk("cold_beats", 32'(blog.size() - b0), 4);
    chk_burst("cold", b0, 0, 32'h1040);
    chk("cold_misses", miss_cnt, 1);
    chk("cold_hits", hit_cnt, 1);

    b0 = blog.size();
    access(0, 32'h1048, 0, 0, st);
    chk("hit_stall", 32'(st), 0);
    chk("hit_no_beats", 32'(blog.size() - b0), 0);
    chk("hit_hits", hit_cnt, 2);

    access(1, 32'h1044, 32'hDEADBEEF, 0, st);
    chk("store_hit_stall", 32'(st), 0);
    b0 = blog.size();
    access(0, 32'h2044, 0, 0, st);
    chk("evict_beats", 32'(blog.size() - b0), 8);
    chk_burst("evict_wb", b0, 1, 32'h1040);
    ev = '{32'hA0, 32'hDEADBEEF, 32'hA2, 32'hA3};
    for (int i = 0; i < 4; i++)
      if (b0 + i < blog.size()) chk("evict_wdata", blog[b0+i].data, ev[i]);
    chk_burst("evict_rf", b0 + 4, 0, 32'h2040);
    chk("evict_stall_len", 32'(st >= 32), 1);
    chk("evict_hits", hit_cnt, 32'(exp_hits));
    chk("evict_misses", miss_cnt, 32'(exp_misses));

    // Sets 4 and 9 dirty, then a flush raised alongside a load.
    access(1, 32'h3090, 32'h1234_5678, 0, st);
    access(1, 32'h2048, 32'h8765_4321, 0, st);
    b0 = blog.size();
    f0 = fdone;
    access(0, 32'h2040, 0, 1, st);
    chk("flush_load_stalled", 32'(st > 0), 1);
    chk("flush_beats", 32'(blog.size() - b0), 12);
    chk_burst("flush_wb4", b0, 1, 32'h2040);
    chk_burst("flush_wb9", b0 + 4, 1, 32'h3090);
    chk_burst("flush_refill", b0 + 8, 0, 32'h2040);
    chk("flush_done_pulses", 32'(fdone - f0), 1);
    chk("flush_misses", miss_cnt, 32'(exp_misses));
    chk("flush_wb_data", dmem_rd(32'h2048), 32'h8765_4321);

    // Reset in the middle of a refill.
    b0 = blog.size();
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_addr_i = 32'h5000;
    n = 0;
    while (blog.size() < b0 + 2 && n < 200) begin @(negedge clk); n++; end
    chk("rst_pre_beats", 32'(blog.size() - b0), 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_mem_req", 32'(bus.mem_req_o), 0);
    chk("rst_mid_hits", hit_cnt, 0);
    chk("rst_mid_misses", miss_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid_i = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    foreach (res_valid[i]) res_valid[i] = 1'b0;
    b0 = blog.size();
    access(0, 32'h5000, 0, 0, st);
    chk("rst_reload_beats", 32'(blog.size() - b0), 4);
    chk_burst("rst_reload", b0, 0, 32'h5000);

    // Random traffic over 4 tags x 16 sets with random wait states and occasional flushes.
    fixed_delay = -1;
    for (int k = 0; k < 300; k++) begin
      a  = (32'($urandom_range(16, 19)) << 8) | (32'($urandom_range(0, 15)) << 4) |
           (32'($urandom_range(0, 3)) << 2);
      we = 1'($urandom_range(0, 1));
      access(we, a, $urandom, ($urandom_range(0, 39) == 0), st);
    end
    chk("rand_hits", hit_cnt, 32'(exp_hits));
    chk("rand_misses", miss_cnt, 32'(exp_misses));

    // Final flush re-armed once while it is running: exactly two completions.
    f0 = fdone;
    @(negedge clk); bus.flush_i = 1'b1;
    @(negedge clk); bus.flush_i = 1'b0;
    repeat (3) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk); bus.flush_i = 1'b0;
    n = 0;
    while (fdone - f0 < 2 && n < 3000) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    chk("rearm_flush_pulses", 32'(fdone - f0), 2);
    foreach (refm[k]) chk("writeback_data", dmem_rd(k), refm[k]);
    chk("sb_drained", 32'(sbq.size()), 0);

    // 8 sets x 1 word, 2-bit counters: single-beat misses, counters stick at 3.
    for (int k = 1; k <= 4; k++) begin
      access2(32'h100 * 32'(k), n);
      chk("cfg2_beats", 32'(n), 1);
      chk("cfg2_misses", 32'(miss2), 32'((k < 3) ? k : 3));
      chk("cfg2_hits", 32'(hit2), 32'((k < 3) ? k : 3));
    end
    repeat (2) @(negedge clk);
    chk("sb2_drained", 32'(sb2.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_wb_param.md
Name: dcache_wb_param

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache. Sits between the LSU-side load/store path and the word-wide memory port.
- Generalises the earlier single-word-line cache in three ways: configurable sets and multi-word lines with burst writeback/refill, an explicit miss FSM with a valid/ready memory handshake, and a full-cache flush command.
- Also provides hit and miss counters for performance monitoring.

Parameters:
- NUM_SETS, 16, number of lines; power of two, >=2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, >=1.
- CNT_W, 32, width of the hit and miss counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  processor access request; address, write enable and write data are held stable while stall_o=1.
- req_we_i  in  1  1=store word, 0=load word.
- req_addr_i  in  32  byte address; bits[1:0] ignored.
- req_wdata_i  in  32  store data.
- stall_o  out  1  processor must hold the request.
- rvalid_o  out  1  load data valid.
- rdata_o  out  32  load data.
- flush_i  in  1  request writeback of all dirty lines and invalidation of the whole cache.
- flush_done_o  out  1  one-cycle pulse when the flush completes.
- mem_req_o  out  1  memory beat request.
- mem_we_o  out  1  1=write beat, 0=read beat.
- mem_addr_o  out  32  word-aligned beat address.
- mem_wdata_o  out  32  write-beat data.
- mem_rdata_i  in  32  read-beat data; valid in the cycle with mem_req_o & mem_ready_i.
- mem_ready_i  in  1  beat completes this cycle.
- hit_count_o  out  CNT_W  saturating hit counter.
- miss_count_o  out  CNT_W  saturating miss counter.

Behaviour:
- Address split:
  - WO = log2(WORDS_PER_LINE) word-select bits at [2+WO-1:2].
  - IX = log2(NUM_SETS) index bits directly above the word-select bits.
  - Tag is bits[31:2+WO+IX].
- Storage:
  - Per line: valid bit, dirty bit, tag, WORDS_PER_LINE data words.
  - rst_i clears all valid and dirty bits. The data array is not reset.
- FSM states: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB.
- IDLE, req_valid_i=1, flush not pending:
  - Combinational lookup; hit = valid & tag match.
  - Load hit: stall_o=0; next cycle rvalid_o=1 and rdata_o=word.
  - Store hit: stall_o=0; word written and dirty set at the clock edge; rvalid_o stays 0.
  - Either hit increments hit_count_o.
  - Miss: stall_o=1 in the same cycle; miss_count_o increments once per miss.
  - Next state on a miss: WRITEBACK if the victim line is valid & dirty, otherwise REFILL.
- WRITEBACK:
  - WORDS_PER_LINE write beats to {victim_tag, index, beat, 2'b00}, beat = 0..W-1 in ascending order.
  - Then go to REFILL.
- REFILL:
  - WORDS_PER_LINE read beats to {req_tag, index, beat, 2'b00}, beat = 0..W-1 in ascending order.
  - Each beat writes the corresponding line word.
  - After the last beat: valid=1, dirty=0, tag updated; go to IDLE.
  - The still-held request then hits. This replay is counted as a hit.
- Beat rules:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable until mem_ready_i=1.
  - The beat counter advances only on mem_req_o & mem_ready_i.
  - mem_req_o=0 in IDLE and FLUSH_SCAN.
- stall_o = 1 whenever state != IDLE. It is also 1 in IDLE when a request misses or a flush is pending.
- Flush:
  - flush_i is latched into a pending flag in any state.
  - The flag is serviced only from IDLE and takes priority over a simultaneous request.
  - FLUSH_SCAN walks sets 0..NUM_SETS-1 at one set per cycle. A dirty line enters FLUSH_WB, which uses the same beat sequence as WRITEBACK, then scanning resumes.
  - After the last set: all valid/dirty bits are cleared, flush_done_o pulses for one cycle, and the FSM returns to IDLE.
  - flush_i asserted during a flush re-arms the flag, so exactly one further flush follows.
- Counters saturate at all-ones and do not wrap.
- Reset:
  - Reset values: stall_o=0, rvalid_o=0, flush_done_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, counters=0, state=IDLE, flush pending cleared.
  - Reset mid-burst abandons the burst. mem_req_o is 0 from the cycle after reset is sampled.
- req_valid_i=0 in IDLE: no lookup, no counter change.

Test Plan:
- Config 16x4. Cold load at 0x0000_1040 (index 4, tag 0x10), memory returns 0xA0..0xA3 -> read beats at 0x1040, 0x1044, 0x1048, 0x104C; then rvalid_o with rdata_o=0xA0; miss_count_o=1, hit_count_o=1.
- Then load 0x1048 -> stall_o=0, rdata_o=0xA2 one cycle later, no mem_req_o, hit_count_o=2.
- Store 0xDEADBEEF to 0x1044, then load 0x2044 -> write beats 0x1040..0x104C carrying 0xA0, 0xDEADBEEF, 0xA2, 0xA3; then read beats 0x2040..0x204C; rdata_o = second refill word.
- mem_ready_i low 3 cycles before every beat -> mem_addr_o/mem_wdata_o held constant; exactly 4 beats per burst; stall_o high throughout.
- Sets 4 and 9 dirty, flush_i pulse concurrent with a load -> load stalled, exactly 8 write beats, one flush_done_o pulse; the following load 0x2040 misses.
- rst_i asserted after 2 refill beats -> mem_req_o=0 next cycle, counters=0; re-issued load misses with a full 4-beat refill.
- Config NUM_SETS=8, WORDS_PER_LINE=1 -> each miss is a single beat. Preset miss counter to all-ones minus 1, cause 2 misses -> saturates at all-ones.
